serial_compare: RTL and testbench
=================================

SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 Parameter W, default 16: operand width in bits; SHALL be a multiple of D and >= D.
REQ-002 Parameter D, default 4: digit width compared per cycle; N = W/D digit cycles per compare.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operands and mode presented.
REQ-006 in_ready  output  1  block can accept; high only in IDLE.
REQ-007 A  input  W  first operand.
REQ-008 B  input  W  second operand.
REQ-009 sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled with A/B.
REQ-010 out_valid  output  1  G/L/E hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 G  output  1  A > B under the sampled mode.
REQ-013 L  output  1  A < B under the sampled mode.
REQ-014 E  output  1  A == B.

Function
REQ-015 FSM states: IDLE, RUN, DONE; the only transitions are IDLE->RUN, RUN->DONE, DONE->IDLE and any state->IDLE on rst.
REQ-016 IDLE: in_ready=1; in_valid=1 at an edge captures A, B and sgn, clears the digit counter and the decided flag, and moves to RUN.
REQ-017 Capture with sgn=1 SHALL invert bit W-1 of both captured operands, so an unsigned digit compare yields the signed order.
REQ-018 RUN: one D-bit digit per cycle, MSB digit first; the counter counts 0..N-1.
REQ-019 First digit pair that differs SHALL latch gt/lt and set decided; later digits SHALL NOT change a decided result.
REQ-020 RUN SHALL always take exactly N cycles (no early exit): deterministic latency.
REQ-021 Capture edge k -> out_valid high after edge k+N; the captured result SHALL be E=1 if no digit was decided.
REQ-022 DONE: out_valid=1 and exactly one of G/L/E is 1; outputs SHALL hold stable until out_valid && out_ready.
REQ-023 DONE with out_ready=1 -> IDLE at that edge; the next capture is possible one cycle later (throughput one compare per N+2 cycles).
REQ-024 in_valid in RUN or DONE SHALL be ignored; A/B/sgn changes after capture SHALL NOT affect the result.
REQ-025 Outside DONE, G=L=E=0 and out_valid=0.
REQ-026 N=1 (W=D) SHALL work: RUN lasts one cycle.

Reset
REQ-027 rst=1 at an edge forces IDLE, in_ready=1, out_valid=0, G=L=E=0, counter=0 and decided=0, regardless of the other inputs.
REQ-028 Reset mid-RUN or mid-DONE SHALL discard the operation with no partial result visible; in_valid during rst SHALL NOT be captured.

Structure
REQ-029 Package compare_pkg SHALL hold the FSM state typedef and a result typedef {LT, EQ, GT}.
REQ-030 One sub-module, cmp_digit: purely combinational D-bit unsigned compare giving gt/lt; instantiated once and fed by the digit selected by the counter.
REQ-031 No other hierarchy; all registers SHALL live in serial_compare.

Verification (W=16, D=4 unless stated)
REQ-032 Unsigned, A=0x1234, B=0x1235 -> L=1 with out_valid exactly 4 cycles after the capture edge.
REQ-033 A=0x8000, B=0x0001: sgn=1 -> L=1; sgn=0 -> G=1; A=B=0xFFFF -> E=1.
REQ-034 A=0xF000, B=0x0FFF, unsigned -> G=1 decided at digit 0 and unchanged by later digits; out_ready low for 3 DONE cycles -> outputs stable, then release -> IDLE.
REQ-035 in_valid pulsed with new operands during RUN -> ignored, first result unchanged; rst asserted in RUN cycle 2 -> IDLE next edge, all outputs 0, no result emitted.
REQ-036 W=4, D=4: all 256 pairs x both sgn values vs. a behavioural signed/unsigned model -> all match, latency 1.

Source files
------------

// File: rtl/compare_pkg.sv
`default_nettype none
// ============================================================================
// Module   : compare_pkg
// Brief    : Shared types for the serial digit-by-digit magnitude comparator.
// Revision : 1.0
// ============================================================================
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LT = 2'd0,
        EQ = 2'd1,
        GT = 2'd2
    } result_t;

    // A single-digit operand still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_digit.sv
`default_nettype none
// ============================================================================
// Module   : cmp_digit
// Brief    : Combinational unsigned compare of one D-bit digit pair.
// Revision : 1.0
// ============================================================================
module cmp_digit #(
    parameter int D = 4
) (
    input  logic [D-1:0] i_a,
    input  logic [D-1:0] i_b,
    output logic         o_gt,
    output logic         o_lt
);

    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);

endmodule
`default_nettype wire

// File: rtl/serial_compare.sv
`default_nettype none
// ============================================================================
// Module   : serial_compare
// Brief    : Compares two W-bit operands one D-bit digit per cycle, MSB first,
//            signed or unsigned, with fixed latency and valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module serial_compare
    import compare_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sgn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         G,
    output logic         L,
    output logic         E
);

    localparam int              c_n    = W / D;
    localparam int              c_cw   = cnt_width(c_n);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [c_cw-1:0] r_cnt;
    logic            r_decided;
    result_t         r_res;

    logic [W-1:0]    w_flip;
    logic [D-1:0]    w_dig_a;
    logic [D-1:0]    w_dig_b;
    logic            w_gt;
    logic            w_lt;
    logic            w_last;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_flip = {sgn, {(W-1){1'b0}}};
    assign w_last = (r_cnt == c_last);

    always_comb begin
        w_dig_a = '0;
        w_dig_b = '0;
        for (int i = 0; i < c_n; i++) begin
            if (r_cnt == c_cw'(i)) begin
                w_dig_a = r_a[W-1-i*D -: D];
                w_dig_b = r_b[W-1-i*D -: D];
            end
        end
    end

    cmp_digit #(
        .D (D)
    ) u_cmp_digit (
        .i_a  (w_dig_a),
        .i_b  (w_dig_b),
        .o_gt (w_gt),
        .o_lt (w_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_res     <= EQ;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a       <= A ^ w_flip;
                        r_b       <= B ^ w_flip;
                        r_cnt     <= '0;
                        r_decided <= 1'b0;
                        r_res     <= EQ;
                    end
                end
                RUN: begin
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    // The most significant differing digit settles the order.
                    if (!r_decided && (w_gt || w_lt)) begin
                        r_decided <= 1'b1;
                        r_res     <= w_gt ? GT : LT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign G         = out_valid && (r_res == GT);
    assign L         = out_valid && (r_res == LT);
    assign E         = out_valid && (r_res == EQ);

endmodule
`default_nettype wire

// File: tb/tb_serial_compare.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_compare
// Brief    : Directed vector bench for serial_compare (W=16/D=4 and W=4/D=4).
// Revision : 1.0
// ============================================================================
module tb_serial_compare;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [15:0] A = '0, B = '0;
    logic        sgn = 1'b0, G, L, E;

    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic [3:0]  s_A = '0, s_B = '0;
    logic        s_sgn = 1'b0, s_G, s_L, s_E;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_compare #(.W(16), .D(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
        .G(G), .L(L), .E(E)
    );

    serial_compare #(.W(4), .D(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_A), .B(s_B), .sgn(s_sgn), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .G(s_G), .L(s_L), .E(s_E)
    );

    localparam logic [2:0] c_g = 3'b100;
    localparam logic [2:0] c_l = 3'b010;
    localparam logic [2:0] c_e = 3'b001;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Capture, wait for out_valid (bounded), return {G,L,E} and latency.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [2:0] res, output int lat);
        A = a; B = b; sgn = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        res = {G, L, E};
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output logic [2:0] res, output int lat);
        s_A = a; s_B = b; s_sgn = s; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (s_out_valid) begin
                lat = c;
                break;
            end
        end
        res = {s_G, s_L, s_E};
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [2:0] res;
        int         lat;
        int         seen;

        vecs[0]  = '{16'h1234, 16'h1235, 1'b0, c_l};
        vecs[1]  = '{16'h8000, 16'h0001, 1'b1, c_l};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, c_g};
        vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, c_e};
        vecs[4]  = '{16'hF000, 16'h0FFF, 1'b0, c_g};
        vecs[5]  = '{16'hF000, 16'h0FFF, 1'b1, c_l};
        vecs[6]  = '{16'h7FFF, 16'h8000, 1'b1, c_g};
        vecs[7]  = '{16'h7FFF, 16'h8000, 1'b0, c_l};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, c_e};
        vecs[9]  = '{16'hFFFF, 16'h0000, 1'b1, c_l};
        vecs[10] = '{16'h1200, 16'h1300, 1'b0, c_l};
        vecs[11] = '{16'hABCD, 16'hABCC, 1'b0, c_g};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_16", {out_valid, in_ready, G, L, E}, 5'b01000);
        check("reset_4", {s_out_valid, s_in_ready, s_G, s_L, s_E}, 5'b01000);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), lat, 4);
        end

        // Held result while the consumer stalls
        out_ready = 1'b0;
        A = 16'hF000; B = 16'h0FFF; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check("stall_lat", lat, 4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_hold%0d", k), {out_valid, in_ready, G, L, E}, 5'b10100);
            @(posedge clk); #1;
        end
        check("stall_still", {out_valid, G}, 2'b11);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", {out_valid, in_ready, G, L, E}, 5'b01000);

        // in_valid and operand changes during RUN/DONE are ignored
        A = 16'h0001; B = 16'h0002; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 16'h0005; B = 16'h0001; sgn = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 2) check("ignore_busy", in_ready, 0);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check("ignore_lat", lat, 4);
        check("ignore_res", {G, L, E}, c_l);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ignore_idle", {out_valid, in_ready}, 2'b01);

        // Reset during RUN cycle 2 with a pending in_valid
        A = 16'h1111; B = 16'h2222; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; A = 16'hFFFF; B = 16'h0000;
        @(posedge clk); #1;
        check("rst_run", {out_valid, in_ready, G, L, E}, 5'b01000);
        rst = 1'b0; in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        check("rst_run_quiet", seen, 0);

        // Reset while a result is held in DONE
        out_ready = 1'b0;
        A = 16'h0002; B = 16'h0001; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_done", {out_valid, G}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_done", {out_valid, in_ready, G, L, E}, 5'b01000);
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        // W=D=4: every pair in both modes against a behavioural model
        for (int sg = 0; sg < 2; sg++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    logic [3:0] a4;
                    logic [3:0] b4;
                    int         va;
                    int         vb;
                    logic [2:0] exp;
                    a4 = 4'(ai);
                    b4 = 4'(bi);
                    va = (sg == 1 && ai >= 8) ? ai - 16 : ai;
                    vb = (sg == 1 && bi >= 8) ? bi - 16 : bi;
                    exp = (va > vb) ? c_g : (va < vb) ? c_l : c_e;
                    run4(a4, b4, sg[0], res, lat);
                    check($sformatf("n1_s%0d_%0d_%0d_res", sg, ai, bi), res, exp);
                    check($sformatf("n1_s%0d_%0d_%0d_lat", sg, ai, bi), lat, 1);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
